// File: rtl/snake_pkg.sv
// snake_pkg: grid geometry, cell types and apple placer state encoding
// shared by the snake game datapath.
package snake_pkg;

  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  localparam int GRID_X_MAX = 13;
  localparam int GRID_Y_MAX = 13;
  localparam int MAX_LEN    = 50;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_SCAN,
    S_DONE,
    S_FAIL
  } rand_st_e;

endpackage

// File: rtl/apple_rand_gen_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11)
// with seed load; a zero seed falls back to SEED.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] l_q;
  logic [15:0] l_d;
  logic        fb;

  assign fb = l_q[15] ^ l_q[13] ^ l_q[12] ^ l_q[10];
  assign q  = l_q;

  always_comb begin
    l_d = {l_q[14:0], fb};
    if (load) begin
      l_d = (seed == 16'h0000) ? SEED : seed;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_q <= SEED;
    end else if (s_reset) begin
      l_q <= SEED;
    end else begin
      l_q <= l_d;
    end
  end

endmodule

// File: rtl/apple_rand_gen.sv
// apple_rand_gen: draws apple cells from an LFSR, rejects off-grid or
// body-occupied candidates and publishes the survivor with a valid pulse.
module apple_rand_gen
  import snake_pkg::*;
#(
  parameter int          MAX_LEN   = snake_pkg::MAX_LEN,
  parameter int          X_MAX     = GRID_X_MAX,
  parameter int          Y_MAX     = GRID_Y_MAX,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 255,
  localparam int         LW        = $clog2(MAX_LEN + 1),
  localparam int         TW        = $clog2(MAX_TRIES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_reset,
  input  logic                    goodColl,
  input  logic [LW-1:0]           body_len,
  input  logic [MAX_LEN-1:0][7:0] body,
  input  logic                    lfsr_load,
  input  logic [15:0]             lfsr_seed,
  output logic [3:0]              randX,
  output logic [3:0]              randY,
  output logic                    rand_valid,
  output logic                    busy,
  output logic                    no_space
);

  localparam coord_t         XM   = coord_t'(X_MAX);
  localparam coord_t         YM   = coord_t'(Y_MAX);
  localparam logic [TW-1:0]  TMAX = TW'(MAX_TRIES);

  rand_st_e      state_q;
  cell_t         cand_q;
  logic [LW-1:0] idx_q;
  logic [TW-1:0] tries_q;
  logic [TW-1:0] tries_d;
  coord_t        randx_q;
  coord_t        randy_q;
  logic          valid_q;
  logic          nospace_q;

  logic [15:0]   lfsr_q;
  logic          lfsr_unused;
  cell_t         cand;
  logic          off_grid;
  logic          hit;
  logic          last;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .s_reset(s_reset),
    .load   (lfsr_load),
    .seed   (lfsr_seed),
    .q      (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:8];
  assign cand        = cell_t'(lfsr_q[7:0]);
  assign off_grid    = (cand.x > XM) || (cand.y > YM);
  assign tries_d     = tries_q + 1'b1;
  assign hit         = cell_t'(body[idx_q]) == cand_q;
  assign last        = idx_q == (body_len - 1'b1);

  // Outputs are loaded on entry to DONE so they are valid during it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_DRAW;
      cand_q    <= '0;
      idx_q     <= '0;
      tries_q   <= '0;
      randx_q   <= '0;
      randy_q   <= '0;
      valid_q   <= 1'b0;
      nospace_q <= 1'b0;
    end else if (s_reset) begin
      state_q   <= S_DRAW;
      cand_q    <= '0;
      idx_q     <= '0;
      tries_q   <= '0;
      randx_q   <= '0;
      randy_q   <= '0;
      valid_q   <= 1'b0;
      nospace_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (goodColl) begin
            state_q <= S_DRAW;
            tries_q <= '0;
          end
        end
        S_DRAW: begin
          cand_q  <= cand;
          tries_q <= tries_d;
          if (tries_d == TMAX) begin
            state_q   <= S_FAIL;
            nospace_q <= 1'b1;
          end else if (off_grid) begin
            state_q <= S_DRAW;
          end else if (body_len == '0) begin
            state_q   <= S_DONE;
            randx_q   <= cand.x;
            randy_q   <= cand.y;
            valid_q   <= 1'b1;
            nospace_q <= 1'b0;
          end else begin
            state_q <= S_SCAN;
            idx_q   <= '0;
          end
        end
        S_SCAN: begin
          if (hit) begin
            state_q <= S_DRAW;
          end else if (last) begin
            state_q   <= S_DONE;
            randx_q   <= cand_q.x;
            randy_q   <= cand_q.y;
            valid_q   <= 1'b1;
            nospace_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_FAIL:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign randX      = randx_q;
  assign randY      = randy_q;
  assign rand_valid = valid_q;
  assign no_space   = nospace_q;
  assign busy       = state_q != S_IDLE;

endmodule
